pattern_bist_driver: RTL and testbench
======================================

Name: pattern_bist_driver

Overview:
- Stimulus transmitter and response compactor for the generated pattern netlists.
- Drives the DUT's primary inputs with an LFSR pattern stream and compacts the DUT's primary outputs into a MISR signature.
- Runs a start/busy/done handshake with the test controller.
- Sits outside the merged pattern module and closes the loop from its outputs back to its inputs for self-test.

Parameters:
- IN_W, 11, stimulus width (DUT primary-input count, excluding clock and reset)
- OUT_W, 9, response width (DUT primary-output count)
- CNT_W, 16, width of pattern counter and num_patterns
- LAT, 2, DUT latency in cycles from stimulus to sampled response (1..8)
- LFSR_TAPS, 11'h500, LFSR feedback mask (x^11+x^9+1)
- MISR_TAPS, 9'h110, MISR feedback mask (x^9+x^5+1)

Ports:
- blif_clk_net  in  1  single clock; all state on the rising edge
- blif_reset_net  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to begin a run
- abort  in  1  cancel the current run
- seed  in  IN_W  LFSR seed, sampled with start; must be nonzero
- num_patterns  in  CNT_W  pattern count, sampled with start
- golden  in  OUT_W  expected signature
- resp  in  OUT_W  DUT outputs
- stim  out  IN_W  registered stimulus; 0 whenever stim_valid=0
- stim_valid  out  1  stim carries a pattern this cycle
- busy  out  1  run in progress
- done  out  1  run completed; level output
- signature  out  OUT_W  MISR contents
- sig_match  out  1  signature==golden; valid while done=1, else 0

Behaviour:
- Reset (async on blif_reset_net=0): all outputs 0, FSM=IDLE, LFSR=0, MISR=0, counter=0, valid pipe cleared. Reset mid-run abandons the run immediately.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE/FIN, start=1, abort=0:
  - Latch seed and num_patterns; clear MISR, done and sig_match; set busy.
  - If num_patterns=0, go to FIN next cycle (done=1, signature=0). Otherwise go to RUN.
- RUN:
  - stim_valid=1 and stim=LFSR every cycle; the first pattern equals seed.
  - LFSR next = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - Counter increments per pattern. After num_patterns patterns, go to DRAIN with stim_valid=0.
- Capture:
  - A valid shift pipe of depth LAT follows stim_valid.
  - The response to the pattern issued in cycle k is present on resp during cycle k+LAT. The MISR samples it at the end of that cycle.
  - MISR next = {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ resp, applied only when the delayed valid=1.
- DRAIN: wait until the valid pipe is empty, then go to FIN.
- FIN: done=1, busy=0, sig_match=(signature==golden). Holds until the next start.
- Timing, for start sampled at the end of cycle 0:
  - stim_valid is high in cycles 1..N.
  - Captures occur in cycles 1+LAT..N+LAT.
  - done=1 and busy=0 from cycle N+LAT+1.
- start while busy: ignored, no effect.
- abort, any state: next cycle FSM=IDLE, busy=0, stim_valid=0, done=0, sig_match=0, valid pipe flushed; signature holds its partial value.
- abort and start in the same cycle: abort wins; start is ignored.
- seed=0: the run proceeds with stim=0 throughout (not checked; it is the controller's responsibility).
- num_patterns=2^CNT_W-1 runs to completion with no counter wrap. The LFSR wraps naturally after period 2^IN_W-1 for maximal taps.

Test Plan:
- Reset mid-run:
  - Stimulus: run N=5, then assert blif_reset_net=0 in cycle 3 without a clock edge.
  - Required: all outputs 0 immediately, FSM=IDLE.
- Basic sequence:
  - Stimulus: seed=11'h001, N=12, LAT=2, resp=0.
  - Required: stim = 001,002,004,008,010,020,040,080,100,201,402,005.
  - Required: done rises at cycle 15 and signature=0.
  - Required: sig_match=1 with golden=0 and 0 with golden=9'h001.
- MISR check:
  - Stimulus: N=3, LAT=2, resp held at 9'h001.
  - Required: MISR steps 001, 003, 007; signature=9'h007 at cycle 6; busy falls at cycle 6.
- Zero-length run:
  - Stimulus: N=0.
  - Required: stim_valid never asserts; done=1 at cycle 1; signature=0.
- Abort:
  - Stimulus: abort in cycle 2 of an N=10 run, with start in that same cycle.
  - Required: cycle 3 has busy=0, stim_valid=0, done=0; the start is ignored; a fresh start afterwards restarts from seed.
- Start while busy:
  - Stimulus: assert start during RUN with a different seed.
  - Required: stim sequence and counter are unaffected; the original run completes normally.

Source files
------------

// File: rtl/pattern_bist_driver.sv
// pattern_bist_driver
// Drives a pattern netlist's primary inputs from an LFSR stream and folds its
// primary outputs into a MISR signature. Start/busy/done handshake toward the
// test controller; the response path is qualified by a LAT-deep valid pipe so
// each capture lines up with the pattern that produced it.
module pattern_bist_driver #(
   parameter int                IN_W      = 11,
   parameter int                OUT_W     = 9,
   parameter int                CNT_W     = 16,
   parameter int                LAT       = 2,
   parameter logic [IN_W-1:0]   LFSR_TAPS = 11'h500,
   parameter logic [OUT_W-1:0]  MISR_TAPS = 9'h110
) (
   input  logic              blif_clk_net,
   input  logic              blif_reset_net,
   input  logic              start,
   input  logic              abort,
   input  logic [IN_W-1:0]   seed,
   input  logic [CNT_W-1:0]  num_patterns,
   input  logic [OUT_W-1:0]  golden,
   input  logic [OUT_W-1:0]  resp,
   output logic [IN_W-1:0]   stim,
   output logic              stim_valid,
   output logic              busy,
   output logic              done,
   output logic [OUT_W-1:0]  signature,
   output logic              sig_match
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // One Fibonacci LFSR step: shift left, feedback is parity of tapped bits.
   function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
      lfsr_step = {v[IN_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

   // One MISR step folding in a response word.
   function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] v,
                                                 input logic [OUT_W-1:0] r);
      misr_step = {v[OUT_W-2:0], ^(v & MISR_TAPS)} ^ r;
   endfunction

   state_t            state_r;
   state_t            state_next_s;
   logic [IN_W-1:0]   lfsr_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  num_r;
   logic [LAT-1:0]    vpipe_r;
   logic [LAT-1:0]    vpipe_next_s;
   logic [OUT_W-1:0]  misr_r;
   logic [OUT_W-1:0]  misr_next_s;
   logic              stim_valid_r;
   logic              busy_r;
   logic              done_r;
   logic              sig_match_r;
   logic              load_s;
   logic              step_s;
   logic              cap_s;

   // Valid pipe shift value; the oldest entry marks the cycle whose resp is captured.
   generate
      if (LAT == 1) begin : g_pipe1
         assign vpipe_next_s = stim_valid_r;
      end else begin : g_pipen
         assign vpipe_next_s = {vpipe_r[LAT-2:0], stim_valid_r};
      end
   endgenerate

   assign cap_s = vpipe_r[LAT-1];

   // FSM state register.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode plus load/step strobes for the datapath; abort overrides all.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      step_s       = 1'b0;
      if (abort) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_FIN: begin
               if (start) begin
                  load_s = 1'b1;
                  if (num_patterns == {CNT_W{1'b0}}) begin
                     state_next_s = ST_FIN;
                  end else begin
                     state_next_s = ST_RUN;
                  end
               end else begin
                  state_next_s = state_r;
               end
            end
            ST_RUN: begin
               // cnt_r counts patterns already issued, including the one on stim now
               if (cnt_r == num_r) begin
                  state_next_s = ST_DRAIN;
               end else begin
                  step_s = 1'b1;
               end
            end
            ST_DRAIN: begin
               if (vpipe_next_s == {LAT{1'b0}}) begin
                  state_next_s = ST_FIN;
               end else begin
                  state_next_s = ST_DRAIN;
               end
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end
   end

   // Next MISR value: cleared on a new run, folds resp on a delayed-valid cycle, holds on abort.
   always_comb begin
      misr_next_s = misr_r;
      if (load_s) begin
         misr_next_s = {OUT_W{1'b0}};
      end else if (cap_s && !abort) begin
         misr_next_s = misr_step(misr_r, resp);
      end else begin
         misr_next_s = misr_r;
      end
   end

   // LFSR / stimulus register; forced to zero whenever no pattern is being driven.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         lfsr_r       <= {IN_W{1'b0}};
         stim_valid_r <= 1'b0;
      end else begin
         stim_valid_r <= (state_next_s == ST_RUN);
         if (state_next_s != ST_RUN) begin
            lfsr_r <= {IN_W{1'b0}};
         end else if (load_s) begin
            lfsr_r <= seed;
         end else if (step_s) begin
            lfsr_r <= lfsr_step(lfsr_r);
         end else begin
            lfsr_r <= lfsr_r;
         end
      end
   end

   // Pattern counter and latched run length; the count starts at 1 for the seed pattern.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         cnt_r <= {CNT_W{1'b0}};
         num_r <= {CNT_W{1'b0}};
      end else if (load_s) begin
         cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
         num_r <= num_patterns;
      end else if (step_s) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         num_r <= num_r;
      end else begin
         cnt_r <= cnt_r;
         num_r <= num_r;
      end
   end

   // Valid pipe tracking patterns in flight through the DUT; flushed on abort.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         vpipe_r <= {LAT{1'b0}};
      end else if (abort) begin
         vpipe_r <= {LAT{1'b0}};
      end else begin
         vpipe_r <= vpipe_next_s;
      end
   end

   // Signature register and handshake/status outputs, all registered from next state.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         misr_r      <= {OUT_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         sig_match_r <= 1'b0;
      end else begin
         misr_r      <= misr_next_s;
         busy_r      <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
         done_r      <= (state_next_s == ST_FIN);
         sig_match_r <= (state_next_s == ST_FIN) && (misr_next_s == golden);
      end
   end

   assign stim       = lfsr_r;
   assign stim_valid = stim_valid_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign signature  = misr_r;
   assign sig_match  = sig_match_r;

endmodule

// File: tb/tb_pattern_bist_driver.sv
// Directed testbench for pattern_bist_driver with hand-computed expectations
// (default parameters: IN_W=11, OUT_W=9, CNT_W=16, LAT=2).
module tb_pattern_bist_driver;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [10:0]   seed;
   logic [15:0]   num_patterns;
   logic [8:0]    golden;
   logic [8:0]    resp;
   logic [10:0]   stim;
   logic          stim_valid;
   logic          busy;
   logic          done;
   logic [8:0]    signature;
   logic          sig_match;

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [10:0] exp_basic [12] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020,
                                   11'h040, 11'h080, 11'h100, 11'h201, 11'h402, 11'h005};

   pattern_bist_driver dut (
      .blif_clk_net   (clk),
      .blif_reset_net (rst_n),
      .start          (start),
      .abort          (abort),
      .seed           (seed),
      .num_patterns   (num_patterns),
      .golden         (golden),
      .resp           (resp),
      .stim           (stim),
      .stim_valid     (stim_valid),
      .busy           (busy),
      .done           (done),
      .signature      (signature),
      .sig_match      (sig_match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; sample point is 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle (cycle 0); returns in cycle 1.
   task automatic launch(input logic [10:0] s, input logic [15:0] n);
      seed         = s;
      num_patterns = n;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_stim"},  32'(stim), 32'(0));
      check_val({tag, "_sv"},    32'(stim_valid), 32'(0));
      check_val({tag, "_busy"},  32'(busy), 32'(0));
      check_val({tag, "_done"},  32'(done), 32'(0));
      check_val({tag, "_sig"},   32'(signature), 32'(0));
      check_val({tag, "_match"}, 32'(sig_match), 32'(0));
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      seed         = 11'h000;
      num_patterns = 16'd0;
      golden       = 9'h000;
      resp         = 9'h000;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Basic sequence: seed 1, N=12, resp=0
      launch(11'h001, 16'd12);
      for (int i = 0; i < 12; i++) begin
         check_val($sformatf("basic_sv%0d", i + 1), 32'(stim_valid), 32'(1));
         check_val($sformatf("basic_stim%0d", i + 1), 32'(stim), 32'(exp_basic[i]));
         tick();
      end
      check_val("basic_sv13", 32'(stim_valid), 32'(0));
      check_val("basic_stim13", 32'(stim), 32'(0));
      tick();
      check_val("basic_done14", 32'(done), 32'(0));
      check_val("basic_busy14", 32'(busy), 32'(1));
      tick();
      check_val("basic_done15", 32'(done), 32'(1));
      check_val("basic_busy15", 32'(busy), 32'(0));
      check_val("basic_sig", 32'(signature), 32'(0));
      check_val("basic_match0", 32'(sig_match), 32'(1));
      golden = 9'h001;
      tick();
      check_val("basic_match1", 32'(sig_match), 32'(0));
      check_val("basic_done_hold", 32'(done), 32'(1));

      // MISR check: N=3, resp held at 1, golden=7
      golden = 9'h007;
      resp   = 9'h001;
      launch(11'h001, 16'd3);
      check_val("misr_done_clr", 32'(done), 32'(0));
      check_val("misr_busy1", 32'(busy), 32'(1));
      tick();
      tick();
      check_val("misr_c3", 32'(signature), 32'(9'h000));
      tick();
      check_val("misr_c4", 32'(signature), 32'(9'h001));
      tick();
      check_val("misr_c5", 32'(signature), 32'(9'h003));
      check_val("misr_busy5", 32'(busy), 32'(1));
      tick();
      check_val("misr_c6", 32'(signature), 32'(9'h007));
      check_val("misr_busy6", 32'(busy), 32'(0));
      check_val("misr_done6", 32'(done), 32'(1));
      check_val("misr_match", 32'(sig_match), 32'(1));
      resp = 9'h000;

      // Zero-length run: signature cleared, done immediately, no stimulus
      golden = 9'h000;
      launch(11'h001, 16'd0);
      for (int i = 1; i <= 3; i++) begin
         check_val($sformatf("zero_sv%0d", i), 32'(stim_valid), 32'(0));
         check_val($sformatf("zero_done%0d", i), 32'(done), 32'(1));
         check_val($sformatf("zero_busy%0d", i), 32'(busy), 32'(0));
         tick();
      end
      check_val("zero_sig", 32'(signature), 32'(0));
      check_val("zero_match", 32'(sig_match), 32'(1));

      // Abort with simultaneous start in cycle 2 of an N=10 run
      launch(11'h001, 16'd10);
      tick();
      check_val("abort_stim2", 32'(stim), 32'(11'h002));
      abort = 1'b1;
      start = 1'b1;
      seed  = 11'h7FF;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check_val("abort_busy3", 32'(busy), 32'(0));
      check_val("abort_sv3", 32'(stim_valid), 32'(0));
      check_val("abort_done3", 32'(done), 32'(0));
      check_val("abort_match3", 32'(sig_match), 32'(0));
      check_val("abort_stim3", 32'(stim), 32'(0));
      tick();
      check_val("abort_busy4", 32'(busy), 32'(0));
      check_val("abort_sv4", 32'(stim_valid), 32'(0));
      launch(11'h055, 16'd2);
      check_val("restart_stim1", 32'(stim), 32'(11'h055));
      check_val("restart_busy1", 32'(busy), 32'(1));
      tick();
      check_val("restart_stim2", 32'(stim), 32'(11'h0AA));
      tick();
      tick();
      tick();
      check_val("restart_done5", 32'(done), 32'(1));

      // Start while busy: a second start with another seed must be ignored
      launch(11'h001, 16'd6);
      for (int i = 0; i < 6; i++) begin
         check_val($sformatf("sbusy_stim%0d", i + 1), 32'(stim), 32'(exp_basic[i]));
         if (i == 1) begin
            seed         = 11'h3FF;
            num_patterns = 16'd1;
            start        = 1'b1;
         end else begin
            start        = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check_val("sbusy_sv7", 32'(stim_valid), 32'(0));
      tick();
      check_val("sbusy_done8", 32'(done), 32'(0));
      tick();
      check_val("sbusy_done9", 32'(done), 32'(1));
      check_val("sbusy_busy9", 32'(busy), 32'(0));

      // Reset mid-run, asserted between clock edges
      launch(11'h001, 16'd5);
      tick();
      tick();
      check_val("rst_busy3", 32'(busy), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      tick();
      check_all_zero("midrst_hold");
      rst_n = 1'b1;
      tick();
      check_val("post_rst_busy", 32'(busy), 32'(0));

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
